// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter
// Round-robin arbiter granting one of NREQ requesters at a time.
// The grant is held until the owner releases it, withdraws its request,
// or the arbiter is disabled. The winner is driven out both as an index
// and as its one-hot decode.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   A hold counter limits a grant to HOLD_MAX cycles. When the limit is
//   hit, the grant is forced off and 'timeout' pulses for one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           arbiter enable; 0 drops any grant and blocks new ones
//   req          request vector, bit i = requester i
//   release_gnt  owner frees the grant this cycle ('release' is a
//                reserved word, hence the longer name)
//   gnt          one-hot grant, zero when no grant is active
//   gnt_idx      index of the current/last owner
//   gnt_valid    a grant is active
//   timeout      one-cycle pulse after a forced release (ARB_TIMEOUT_EN only)
//
// State table:
//   IDLE  | no owner; arbitrate from ptr when enabled and requests pending
//   GRANT | gnt_idx owns the resource until a release condition
module rr_dec_arbiter #(
    parameter int NREQ  = 8,
    parameter int IDX_W = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int HOLD_MAX = 15
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    input  logic             release_gnt,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             leave;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_next;
    logic       hold_hit;
    logic       forced;

    assign hold_next = hold_cnt + 8'd1;
    // hold_next counts the current cycle, so hitting HOLD_MAX here means
    // this is the last permitted grant cycle.
    assign hold_hit  = (state == GRANT) && (hold_next == 8'(HOLD_MAX));
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        idx_next   = gnt_idx;
        leave      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        forced     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    state_next = GRANT;
                    idx_next   = pick_idx;
                end
            end
            GRANT: begin
                if (release_gnt || !req[gnt_idx] || !en) begin
                    leave = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                // A normal release on the same cycle takes precedence, so
                // the timeout pulse only marks true forced releases.
                else if (hold_hit) begin
                    forced = 1'b1;
                    leave  = 1'b1;
                end
`endif
                if (leave) begin
                    state_next = IDLE;
                    ptr_next   = gnt_idx + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            gnt_idx <= idx_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= forced;
            if (state == GRANT && state_next == GRANT) begin
                hold_cnt <= hold_next;
            end else begin
                hold_cnt <= 8'd0;
            end
        end
    end
`endif

    assign gnt_valid = (state == GRANT);
    assign gnt       = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
module tb_rr_dec_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       release_gnt;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    rr_dec_arbiter #(.NREQ(8), .IDX_W(3), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .release_gnt(release_gnt),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );
`else
    rr_dec_arbiter #(.NREQ(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .release_gnt(release_gnt),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );
`endif

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       rel;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t vt[$];

    task automatic add(input string name, input logic r, input logic e,
                       input logic [7:0] q, input logic rl,
                       input logic [7:0] g, input logic [2:0] i, input logic v);
        vec_t x;
        x.name = name; x.rst = r; x.en = e; x.req = q; x.rel = rl;
        x.gnt = g; x.idx = i; x.valid = v;
        vt.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] q, input logic rl);
        @(negedge clk);
        rst = r; en = e; req = q; release_gnt = rl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; release_gnt = 1'b0;

        //   name          rst en  req    rel  gnt    idx  valid
        add("reset0",      1, 0, 8'h00, 0, 8'h00, 3'd0, 0);
        add("reset1",      1, 0, 8'h00, 0, 8'h00, 3'd0, 0);
        add("noreq0",      0, 1, 8'h00, 0, 8'h00, 3'd0, 0);
        add("noreq1",      0, 1, 8'h00, 0, 8'h00, 3'd0, 0);
        add("noreq2",      0, 1, 8'h00, 0, 8'h00, 3'd0, 0);
        // round-robin over 1000_0101, release one cycle after each grant
        add("rr_g0",       0, 1, 8'h85, 0, 8'h01, 3'd0, 1);
        add("rr_r0",       0, 1, 8'h85, 1, 8'h00, 3'd0, 0);
        add("rr_g2",       0, 1, 8'h85, 0, 8'h04, 3'd2, 1);
        add("rr_r2",       0, 1, 8'h85, 1, 8'h00, 3'd2, 0);
        add("rr_g7",       0, 1, 8'h85, 0, 8'h80, 3'd7, 1);
        add("rr_r7",       0, 1, 8'h85, 1, 8'h00, 3'd7, 0);
        add("rr_wrap0",    0, 1, 8'h85, 0, 8'h01, 3'd0, 1);
        add("rr_rw",       0, 1, 8'h85, 1, 8'h00, 3'd0, 0);
        add("rel_idle",    0, 1, 8'h00, 1, 8'h00, 3'd0, 0);
        // withdraw by owner 3, then 3 and 5 together: ptr=4 favours 5
        add("wd_g3",       0, 1, 8'h08, 0, 8'h08, 3'd3, 1);
        add("wd_hold",     0, 1, 8'h08, 0, 8'h08, 3'd3, 1);
        add("wd_drop",     0, 1, 8'h00, 0, 8'h00, 3'd3, 0);
        add("wd_g5",       0, 1, 8'h28, 0, 8'h20, 3'd5, 1);
        add("other_req",   0, 1, 8'h2F, 0, 8'h20, 3'd5, 1);
        add("wd_r5",       0, 1, 8'h28, 1, 8'h00, 3'd5, 0);
        // en drop during grant on 6
        add("en_g6",       0, 1, 8'h40, 0, 8'h40, 3'd6, 1);
        add("en_drop",     0, 0, 8'h40, 0, 8'h00, 3'd6, 0);
        add("en_off_ff0",  0, 0, 8'hFF, 0, 8'h00, 3'd6, 0);
        add("en_off_ff1",  0, 0, 8'hFF, 0, 8'h00, 3'd6, 0);
        add("en_g7",       0, 1, 8'hFF, 0, 8'h80, 3'd7, 1);
        add("en_r7",       0, 1, 8'hFF, 1, 8'h00, 3'd7, 0);
        // move ptr to 2, grant 4, reset mid-grant, ptr must be back at 0
        add("rs_g1",       0, 1, 8'h02, 0, 8'h02, 3'd1, 1);
        add("rs_r1",       0, 1, 8'h02, 1, 8'h00, 3'd1, 0);
        add("rs_g4",       0, 1, 8'h10, 0, 8'h10, 3'd4, 1);
        add("rs_hold4",    0, 1, 8'h10, 0, 8'h10, 3'd4, 1);
        add("rs_mid",      1, 1, 8'h10, 0, 8'h00, 3'd0, 0);
        add("rs_g0",       0, 1, 8'h11, 0, 8'h01, 3'd0, 1);

        foreach (vt[n]) begin
            step(vt[n].rst, vt[n].en, vt[n].req, vt[n].rel);
            check({vt[n].name, ".gnt"},   32'(gnt),       32'(vt[n].gnt));
            check({vt[n].name, ".idx"},   32'(gnt_idx),   32'(vt[n].idx));
            check({vt[n].name, ".valid"}, 32'(gnt_valid), 32'(vt[n].valid));
        end

        // Long hold by requester 1, with requester 2 also pending.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        check("hold.first_gnt", 32'(gnt), 32'h02);
`ifdef ARB_TIMEOUT_EN
        check("hold.first_to", 32'(timeout), 32'd0);
        for (int c = 1; c < 4; c++) begin
            step(0, 1, 8'h06, 0);
            check($sformatf("to.held%0d", c), 32'(gnt), 32'h02);
            check($sformatf("to.pulse_low%0d", c), 32'(timeout), 32'd0);
        end
        step(0, 1, 8'h06, 0);
        check("to.forced_valid", 32'(gnt_valid), 32'd0);
        check("to.pulse", 32'(timeout), 32'd1);
        step(0, 1, 8'h06, 0);
        check("to.next_gnt", 32'(gnt), 32'h04);
        check("to.pulse_end", 32'(timeout), 32'd0);
`else
        for (int c = 1; c <= 22; c++) begin
            step(0, 1, 8'h06, 0);
            check($sformatf("persist%0d", c), 32'(gnt), 32'h02);
        end
        step(0, 1, 8'h06, 1);
        check("persist.release", 32'(gnt_valid), 32'd0);
        step(0, 1, 8'h06, 0);
        check("persist.next_gnt", 32'(gnt), 32'h04);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- Round-robin arbiter sharing one 8-output decoded select resource among 8 requesters.
- Output is the granted index (3-bit) plus its one-hot decoded form, gated by an enable.
- Grants are held until the owner releases or withdraws its request.
- Sits in front of the 3-to-8 decoder path and drives its in/en inputs from arbitration state.

Parameters:
- NREQ, 8, number of requesters; the one-hot grant width. Only 8 is supported.
- IDX_W, 3, width of the grant index; must equal log2(NREQ).
- HOLD_MAX, 15, maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined. Range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; 0 forces the grant off.
- req  input  8  request vector; bit i = requester i.
- release  input  1  current owner frees the grant this cycle.
- gnt  output  8  one-hot grant; decoded form of gnt_idx when gnt_valid=1, else 8'b0.
- gnt_idx  output  3  index of the current owner; holds last value when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release. Exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, gnt=8'b0, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=3'd0; hold counter=0.
  - Reset takes priority over every other input, including mid-grant.
- State IDLE:
  - Condition: en=1 and req!=0.
  - Action: select the first set bit of req scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Next edge: state=GRANT, gnt_idx=selected, gnt=1<<selected, gnt_valid=1.
  - Latency: request sampled at edge k gives the grant visible after edge k (1 cycle).
  - With en=0 or req=0, the block stays in IDLE and outputs are unchanged.
- State GRANT: returns to IDLE at the next edge on any of these:
  - release=1;
  - req[gnt_idx]=0 (owner withdrew);
  - en=0.
- On leaving GRANT:
  - gnt=0, gnt_valid=0.
  - ptr=gnt_idx+1 mod 8 (wrap 7 to 0). The releasing owner becomes lowest priority.
  - hold counter=0.
- Otherwise GRANT holds; gnt and gnt_idx are stable.
- The release input is ignored in IDLE.
- Minimum gap between two grants is one IDLE cycle (one bubble), even if requests are pending.
- Simultaneous release and other requests: release wins this cycle. The next grant is computed in the following IDLE cycle from the updated ptr.
- At most one bit of gnt is ever set. gnt always equals the decode of gnt_idx while gnt_valid=1.
- req bits changing in GRANT, other than the owner's bit, have no effect.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter increments on every GRANT cycle.
  - When the counter reaches HOLD_MAX with no release condition, the block leaves GRANT at the next edge exactly like a release (ptr advances).
  - timeout pulses 1 for the first IDLE cycle after the forced release.
  - If a normal release condition coincides with the counter reaching HOLD_MAX, it is a normal release and timeout stays 0.
- Undefined:
  - No counter and no timeout port.
  - Grants are held indefinitely while the owner requests.

Test Plan:
1. rst=1 for 2 cycles, then rst=0, en=1, req=8'h00 -> gnt=8'h00, gnt_valid=0, gnt_idx=0 every cycle.
2. Round-robin order:
   - Stimulus: req=8'b1000_0101 held; release=1 one cycle after each grant.
   - Required: grants in order idx 0 (gnt=8'h01), 2 (8'h04), 7 (8'h80), 0 (8'h01). One IDLE bubble between grants; ptr wraps 7 to 0.
3. Withdraw and en drop:
   - Owner idx 3 holds (req=8'h08). Deassert req[3] -> gnt_valid=0 next cycle, ptr=4.
   - Re-request idx 3 and idx 5 together -> idx 5 is granted first.
4. en=0 during a grant on idx 6 -> gnt=8'h00 next edge.
   - With en held 0 and req=8'hFF, no grant is issued.
   - After en=1, idx 7 is granted.
5. rst=1 asserted mid-grant (idx 4 active) -> next edge gnt=0, gnt_idx=0, ptr=0. With req=8'h11, the next grant is idx 0.
6. ARB_TIMEOUT_EN, HOLD_MAX=4:
   - Stimulus: idx 1 holds req, never releases.
   - Required: gnt_valid is 1 for exactly 4 cycles, then timeout=1 for one cycle. Then idx 2 is granted if requesting, else idx 1 again.
   - Without the macro, the grant persists for at least 20 cycles.
